// File: rtl/xdma_pkg.sv
// Descriptor/request field layout and FSM state shared by the chunk splitter slice.
package xdma_pkg;
   localparam int DSC_LEN_LSB  = 0;
   localparam int DSC_LEN_W    = 23;
   localparam int DSC_LAST_BIT = 31;
   localparam int DSC_ADDR_LSB = 32;
   localparam int DSC_ADDR_W   = 64;
   localparam int DSC_TAG_LSB  = 96;
   localparam int DSC_TAG_W    = 8;
   localparam int DSC_W        = 104;

   localparam int REQ_ADDR_LSB = 0;
   localparam int REQ_LEN_LSB  = 64;
   localparam int REQ_W        = 96;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_t;
endpackage

// File: rtl/xdma_chunk_splitter_if.sv
// AXI-Stream style valid/ready bus; W selects request (96) or descriptor (104) width.
interface xdma_chunk_splitter_if
   import xdma_pkg::*;
#(
   parameter int W = REQ_W
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/xdma_chunk_calc.sv
// Combinational chunk length: min(remaining, bytes left to the next aligned boundary), plus last flag.
// Zero latency, no handshake.
module xdma_chunk_calc
   import xdma_pkg::*;
#(
   parameter int CHUNK_LOG2 = 16
)(
   input  logic [CHUNK_LOG2-1:0] addr_off,
   input  logic [31:0]           remaining,
   output logic [DSC_LEN_W-1:0]  len,
   output logic                  last
);
   localparam logic [DSC_LEN_W-1:0] CHUNK_BYTES = DSC_LEN_W'(1) << CHUNK_LOG2;

   logic [DSC_LEN_W-1:0] room;

   always_comb begin
      room = CHUNK_BYTES - DSC_LEN_W'(addr_off);
      len  = room;
      if (remaining < 32'(room)) begin
         len = remaining[DSC_LEN_W-1:0];
      end
      last = (32'(len) == remaining);
   end
endmodule

// File: rtl/xdma_chunk_splitter.sv
// Splits host requests (base, length) into descriptors that never exceed or cross a 2^CHUNK_LOG2 boundary.
// One cycle from request to first descriptor; descriptors held under backpressure, one per cycle otherwise.
module xdma_chunk_splitter
   import xdma_pkg::*;
#(
   parameter int CHUNK_LOG2 = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   xdma_chunk_splitter_if.slave  S_AXIS,
   xdma_chunk_splitter_if.master M_AXIS,
   output logic [31:0]           req_count,
   output logic [31:0]           dsc_count,
   output logic [15:0]           zero_len_count,
   output logic                  busy
);
   state_t               state, state_nxt;
   logic [63:0]          cur_addr;
   logic [31:0]          remaining;
   logic [DSC_TAG_W-1:0] tag;
   logic [DSC_LEN_W-1:0] chunk_len;
   logic                 chunk_last;
   logic [63:0]          req_addr;
   logic [31:0]          req_len;
   logic                 s_hs;
   logic                 m_hs;

   assign req_addr = S_AXIS.tdata[REQ_ADDR_LSB +: 64];
   assign req_len  = S_AXIS.tdata[REQ_LEN_LSB +: 32];

   assign S_AXIS.tready = (state == IDLE) && !reset;
   assign M_AXIS.tvalid = (state == SPLIT);
   assign busy          = (state == SPLIT);
   assign s_hs          = S_AXIS.tvalid && S_AXIS.tready;
   assign m_hs          = M_AXIS.tvalid && M_AXIS.tready;

   xdma_chunk_calc #(.CHUNK_LOG2(CHUNK_LOG2)) u_calc (
      .addr_off  (cur_addr[CHUNK_LOG2-1:0]),
      .remaining (remaining),
      .len       (chunk_len),
      .last      (chunk_last)
   );

   // Descriptor is a pure function of registered state, so it stays put while stalled.
   always_comb begin
      M_AXIS.tdata = '0;
      if (state == SPLIT) begin
         M_AXIS.tdata[DSC_LEN_LSB +: DSC_LEN_W]   = chunk_len;
         M_AXIS.tdata[DSC_LAST_BIT]               = chunk_last;
         M_AXIS.tdata[DSC_ADDR_LSB +: DSC_ADDR_W] = cur_addr;
         M_AXIS.tdata[DSC_TAG_LSB +: DSC_TAG_W]   = tag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (s_hs && (req_len != 32'd0)) state_nxt = SPLIT;
         SPLIT:   if (m_hs && chunk_last)         state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_addr       <= '0;
         remaining      <= '0;
         tag            <= '0;
         req_count      <= '0;
         dsc_count      <= '0;
         zero_len_count <= '0;
      end else begin
         if (s_hs && (req_len != 32'd0)) begin
            cur_addr  <= req_addr;
            remaining <= req_len;
            req_count <= req_count + 32'd1;
         end
         if (s_hs && (req_len == 32'd0) && (zero_len_count != 16'hFFFF)) begin
            zero_len_count <= zero_len_count + 16'd1;
         end
         if (m_hs) begin
            cur_addr  <= cur_addr + 64'(chunk_len);
            remaining <= remaining - 32'(chunk_len);
            dsc_count <= dsc_count + 32'd1;
            if (chunk_last) begin
               tag <= tag + 8'd1;
            end
         end
      end
   end
endmodule

// File: doc/xdma_chunk_splitter.md
Name: xdma_chunk_splitter

Overview:
- Sits directly upstream of the XDMA descriptor generator.
- Accepts host transfer requests as base address plus total byte length, and splits each request into descriptors.
- Each descriptor is at most 2^CHUNK_LOG2 bytes and never crosses a 2^CHUNK_LOG2-aligned address boundary.
- Descriptors leave on the 104-bit AXI-Stream consumed by the descriptor generator: addr in [95:32], len in [22:0].

Parameters:
- CHUNK_LOG2, 16: log2 of the maximum descriptor size and of the alignment boundary. Legal range 12..22, so one chunk always fits the 23-bit len field.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- S_AXIS_tdata  in  96  request: [63:0] base address, [95:64] total length in bytes.
- S_AXIS_tvalid  in  1  request valid.
- S_AXIS_tready  out  1  request accepted when tvalid && tready.
- M_AXIS_tdata  out  104  descriptor: [22:0] len, [30:23] zero, [31] last chunk of request, [95:32] addr, [103:96] request tag.
- M_AXIS_tvalid  out  1  descriptor valid.
- M_AXIS_tready  in  1  downstream ready.
- req_count  out  32  non-zero requests accepted.
- dsc_count  out  32  descriptors handed off.
- zero_len_count  out  16  zero-length requests dropped; saturates at 0xFFFF.
- busy  out  1  high while in SPLIT.

Behaviour:
- Reset values (active during the reset cycle and after): state IDLE, S_AXIS_tready=0 during reset, M_AXIS_tvalid=0, M_AXIS_tdata=0, all counters 0, tag=0, busy=0.
- S_AXIS_tready = (state==IDLE) && !reset.
- State IDLE:
  - On a request handshake with length==0: stay IDLE, zero_len_count+1 (saturating), no descriptor, tag unchanged.
  - On a request handshake with length!=0: latch cur_addr=base and remaining=length; register the first descriptor; M_AXIS_tvalid=1 next cycle; go to SPLIT; req_count+1.
  - Latency is one cycle from request handshake to first M_AXIS_tvalid.
- Chunk size: room = 2^CHUNK_LOG2 - cur_addr[CHUNK_LOG2-1:0]; len = min(remaining, room).
  - Computed combinationally from the cur_addr/remaining registers.
  - The result fits 23 bits; tdata[22:0] is zero-extended.
- Last flag: bit 31 = (len == remaining).
- State SPLIT:
  - M_AXIS_tdata and tvalid hold stable while tvalid && !tready (AXIS rule).
  - On an output handshake: dsc_count+1, cur_addr += len (modulo 2^64, wrap permitted), remaining -= len.
  - If the handshaken descriptor was last: tvalid=0, tag+1 (mod 256), go to IDLE; S_AXIS_tready returns high the following cycle. This one-cycle bubble between requests is required.
  - Otherwise: the next descriptor is presented in the cycle after the handshake, so back-to-back descriptors are possible at one per cycle.
- Tag: every descriptor of one request carries the same tag.
- Counters: req_count and dsc_count wrap at 2^32.
- Reset mid-operation: the in-flight request is abandoned; no further descriptors; tvalid drops the cycle after reset asserts; tag returns to 0.
- No combinational path from M_AXIS_tready to M_AXIS_tvalid or tdata. M_AXIS_tready may feed only register enables.

Decomposition:
- Shared package xdma_pkg holds:
  - descriptor field constants: DSC_LEN_LSB=0, DSC_LEN_W=23, DSC_LAST_BIT=31, DSC_ADDR_LSB=32, DSC_ADDR_W=64, DSC_TAG_LSB=96, DSC_TAG_W=8, DSC_W=104;
  - request field constants: REQ_ADDR_LSB=0, REQ_LEN_LSB=64, REQ_W=96;
  - state enum {IDLE, SPLIT}.
- One natural sub-module, xdma_chunk_calc: a purely combinational min(remaining, room) plus last-flag computation, unit-testable in isolation.

Test Plan:
- CHUNK_LOG2=16, addr 0x0000_0001_0000_0000, len 0x30000, tready=1 -> three descriptors, 0x10000 each, at 0x1_0000_0000, 0x1_0001_0000, 0x1_0002_0000; last=1 only on the third; tag 0; dsc_count=3, req_count=1.
- Unaligned: addr 0xFFF0, len 0x20 -> (0xFFF0, 0x10, last=0), (0x10000, 0x10, last=1); second request then carries tag 1.
- Zero length: request len 0 -> no M_AXIS_tvalid; zero_len_count=1; req_count and tag unchanged; S_AXIS_tready stays 1.
- Backpressure: len 0x18000, M_AXIS_tready low 5 cycles after the first tvalid -> tdata bit-stable (0x10000 chunk) throughout; then 0x8000 chunk with last=1; total 2 descriptors.
- Address wrap: addr 0xFFFF_FFFF_FFFF_FFF0, len 0x20 -> (0xFFFF_FFFF_FFFF_FFF0, 0x10), (0x0, 0x10, last=1).
- Reset mid-request: len 0x40000, assert reset after the 2nd handshake -> tvalid 0 the next cycle; counters, tag and busy 0; a fresh request afterwards produces tag 0 starting at its own base address.
